// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if -- bundle of the two request channels, the ALU-side
// operand/result wires and the response channel of alu_arbiter.
//   slave  : the arbiter's view (accepts requests, drives ALU and response)
//   master : the environment's view (issue logic, ALU, result consumer)
// Signals:
//   reqN_valid/reqN_ready, reqN_rs/rt/shamt/funct  requester N (N = 0, 1)
//   alu_rs/alu_rt/alu_shamt/alu_funct -> ALU, alu_rd <- ALU
//   resp_valid/resp_ready, resp_id, resp_rd, resp_err  result channel
interface alu_arbiter_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int FUNCT_W = 6
);
  logic               req0_valid, req0_ready;
  logic [DATA_W-1:0]  req0_rs, req0_rt;
  logic [SHAMT_W-1:0] req0_shamt;
  logic [FUNCT_W-1:0] req0_funct;
  logic               req1_valid, req1_ready;
  logic [DATA_W-1:0]  req1_rs, req1_rt;
  logic [SHAMT_W-1:0] req1_shamt;
  logic [FUNCT_W-1:0] req1_funct;
  logic [DATA_W-1:0]  alu_rs, alu_rt, alu_rd;
  logic [SHAMT_W-1:0] alu_shamt;
  logic [FUNCT_W-1:0] alu_funct;
  logic               resp_valid, resp_ready, resp_id, resp_err;
  logic [DATA_W-1:0]  resp_rd;

  modport slave (
    input  req0_valid, req0_rs, req0_rt, req0_shamt, req0_funct,
    input  req1_valid, req1_rs, req1_rt, req1_shamt, req1_funct,
    output req0_ready, req1_ready,
    output alu_rs, alu_rt, alu_shamt, alu_funct,
    input  alu_rd,
    output resp_valid, resp_id, resp_rd, resp_err,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_rs, req0_rt, req0_shamt, req0_funct,
    output req1_valid, req1_rs, req1_rt, req1_shamt, req1_funct,
    input  req0_ready, req1_ready,
    input  alu_rs, alu_rt, alu_shamt, alu_funct,
    output alu_rd,
    input  resp_valid, resp_id, resp_rd, resp_err,
    output resp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter -- shares one combinational ALU between two requesters.
// Round-robin grant in IDLE, one EXEC cycle driving the ALU from the
// operand registers, then RESP holds the captured result until accepted.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  alu_arbiter_if.slave (request, ALU and response channels)
// Optional feature macro: ALU_ARB_BADOP_CHECK_EN -- when defined, a granted
// op with a funct other than add/sub/srl bypasses EXEC and responds with
// resp_rd = 0, resp_err = 1 one cycle earlier. When undefined every funct
// goes to the ALU and resp_err is always 0.
module alu_arbiter #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int FUNCT_W = 6
) (
  input logic           clk,
  input logic           rst,
  alu_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e             state_q, state_d;
  logic               rr_q, rr_d;        // preferred requester on contention
  logic               id_q, id_d;        // owner of the op in flight
  logic [DATA_W-1:0]  rs_q, rs_d, rt_q, rt_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [FUNCT_W-1:0] funct_q, funct_d;
  logic               resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]  resp_rd_q, resp_rd_d;
  logic               resp_err_q, resp_err_d;
  logic               gnt, gnt_id;

`ifdef ALU_ARB_BADOP_CHECK_EN
  localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] FN_SRL = FUNCT_W'(6'b000010);
  logic [FUNCT_W-1:0] funct_sel;
  assign funct_sel = gnt_id ? bus.req1_funct : bus.req0_funct;
`endif

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    id_d         = id_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    shamt_d      = shamt_q;
    funct_d      = funct_q;
    resp_valid_d = resp_valid_q;
    resp_rd_d    = resp_rd_q;
    resp_err_d   = resp_err_q;
    gnt          = 1'b0;
    gnt_id       = rr_q;
    case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          gnt = 1'b1;
          // rr pointer only matters when both ask
          gnt_id  = (bus.req0_valid && bus.req1_valid) ? rr_q : bus.req1_valid;
          rr_d    = ~gnt_id;
          id_d    = gnt_id;
          rs_d    = gnt_id ? bus.req1_rs    : bus.req0_rs;
          rt_d    = gnt_id ? bus.req1_rt    : bus.req0_rt;
          shamt_d = gnt_id ? bus.req1_shamt : bus.req0_shamt;
          funct_d = gnt_id ? bus.req1_funct : bus.req0_funct;
          resp_err_d = 1'b0;
          state_d    = EXEC;
`ifdef ALU_ARB_BADOP_CHECK_EN
          if (funct_sel != FN_ADD && funct_sel != FN_SUB && funct_sel != FN_SRL) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rd_d    = '0;
            resp_err_d   = 1'b1;
          end
`endif
        end
      end
      EXEC: begin
        resp_rd_d    = bus.alu_rd;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      id_q         <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      shamt_q      <= '0;
      funct_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      id_q         <= id_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      shamt_q      <= shamt_d;
      funct_q      <= funct_d;
      resp_valid_q <= resp_valid_d;
      resp_rd_q    <= resp_rd_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Ready is the combinational grant; forced low while reset is held.
  assign bus.req0_ready = gnt && !gnt_id && !rst;
  assign bus.req1_ready = gnt &&  gnt_id && !rst;

  assign bus.alu_rs     = rs_q;
  assign bus.alu_rt     = rt_q;
  assign bus.alu_shamt  = shamt_q;
  assign bus.alu_funct  = funct_q;

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = id_q;
  assign bus.resp_rd    = resp_rd_q;
`ifdef ALU_ARB_BADOP_CHECK_EN
  assign bus.resp_err   = resp_err_q;
`else
  assign bus.resp_err   = 1'b0;
  logic unused_err;
  assign unused_err = resp_err_q;
`endif
endmodule
